// File: rtl/opb_register_simulink2ppc_pkg.sv
// Shared definitions for the fabric-to-PPC OPB software register: register map,
// status/control bit positions and the ack FSM state type.
package opb_register_simulink2ppc_pkg;

  localparam logic [7:0] REG_DATA    = 8'h00;
  localparam logic [7:0] REG_STATUS  = 8'h04;
  localparam logic [7:0] REG_CONTROL = 8'h08;

  // The slave decodes word offsets (byte offset bits 7..2).
  localparam logic [5:0] WOFF_DATA    = REG_DATA[7:2];
  localparam logic [5:0] WOFF_STATUS  = REG_STATUS[7:2];
  localparam logic [5:0] WOFF_CONTROL = REG_CONTROL[7:2];

  localparam int ST_FRESH_BIT   = 0;
  localparam int ST_OVERRUN_BIT = 1;
  localparam int ST_FREEZE_BIT  = 2;
  localparam int ST_COUNT_LSB   = 16;

  localparam int CTRL_CLEAR_BIT  = 0;
  localparam int CTRL_FREEZE_BIT = 1;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } ack_state_t;

  typedef struct packed {
    logic [15:0] count;
    logic        freeze;
    logic        overrun;
    logic        fresh;
  } status_t;

  function automatic logic [31:0] pack_status(input status_t s);
    logic [31:0] w;
    w = '0;
    w[ST_COUNT_LSB +: 16] = s.count;
    w[ST_FREEZE_BIT]      = s.freeze;
    w[ST_OVERRUN_BIT]     = s.overrun;
    w[ST_FRESH_BIT]       = s.fresh;
    return w;
  endfunction

endpackage

// File: rtl/opb_slave_ack_fsm.sv
// OPB slave address decode and single-cycle acknowledge FSM, shared by the
// software-register blocks. Strobes and offset are registered and valid in ACK.
module opb_slave_ack_fsm
  import opb_register_simulink2ppc_pkg::*;
#(
  parameter int                      C_OPB_AWIDTH = 32,
  parameter logic [C_OPB_AWIDTH-1:0] C_BASEADDR   = 32'h01100200,
  parameter logic [C_OPB_AWIDTH-1:0] C_HIGHADDR   = 32'h011002FF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [0:C_OPB_AWIDTH-1] abus,
  input  logic                  select,
  input  logic                  rnw,
  output logic                  hit,
  output logic [5:0]            hit_offset,
  output logic                  ack,
  output logic                  rd_strobe,
  output logic                  wr_strobe,
  output logic [5:0]            offset
);

  ack_state_t state;

  // A hit is only recognised from IDLE, so a select held through the ack
  // cycle starts a fresh transaction rather than extending the old one.
  assign hit        = (state == IDLE) && select &&
                      (abus >= C_BASEADDR) && (abus <= C_HIGHADDR);
  assign hit_offset = abus[C_OPB_AWIDTH-8 : C_OPB_AWIDTH-3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ack       <= 1'b0;
      rd_strobe <= 1'b0;
      wr_strobe <= 1'b0;
      offset    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            state     <= ACK;
            ack       <= 1'b1;
            rd_strobe <= rnw;
            wr_strobe <= ~rnw;
            offset    <= hit_offset;
          end
        end
        ACK: begin
          state     <= IDLE;
          ack       <= 1'b0;
          rd_strobe <= 1'b0;
          wr_strobe <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          ack       <= 1'b0;
          rd_strobe <= 1'b0;
          wr_strobe <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/opb_register_simulink2ppc.sv
// Fabric-to-PPC software register: captures fabric words on a valid strobe and
// serves them, plus fresh/overrun/count status and a freeze control, over OPB.
module opb_register_simulink2ppc
  import opb_register_simulink2ppc_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h01100200,
  parameter logic [31:0] C_HIGHADDR   = 32'h011002FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter string       C_FAMILY     = "virtex6"
) (
  input  logic                    OPB_Clk,
  input  logic                    OPB_Rst_n,
  input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
  input  logic [0:3]              OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
  input  logic                    OPB_RNW,
  input  logic                    OPB_select,
  input  logic                    OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
  output logic                    Sl_errAck,
  output logic                    Sl_retry,
  output logic                    Sl_toutSup,
  output logic                    Sl_xferAck,
  input  logic [31:0]             user_data_in,
  input  logic                    user_data_valid,
  output logic                    user_overrun
);

  localparam string unused_family = C_FAMILY;

  logic        hit;
  logic [5:0]  hit_offset;
  logic        ack;
  logic        rd_strobe;
  logic        wr_strobe;
  logic [5:0]  offset;

  logic [31:0] data_reg;
  logic        fresh;
  logic        overrun;
  logic        freeze;
  logic [15:0] count;

  logic [31:0] rd_q;
  logic [31:0] rd_mux;
  status_t     status;
  logic        wr_clear_q;
  logic        wr_freeze_q;
  logic        wr_be_q;

  logic        capture;
  logic        data_read;
  logic        ctrl_write;
  logic        ctrl_clear;
  logic        unused_bits;

  opb_slave_ack_fsm #(
    .C_OPB_AWIDTH (C_OPB_AWIDTH),
    .C_BASEADDR   (C_BASEADDR[C_OPB_AWIDTH-1:0]),
    .C_HIGHADDR   (C_HIGHADDR[C_OPB_AWIDTH-1:0])
  ) u_ack_fsm (
    .clk        (OPB_Clk),
    .rst_n      (OPB_Rst_n),
    .abus       (OPB_ABus),
    .select     (OPB_select),
    .rnw        (OPB_RNW),
    .hit        (hit),
    .hit_offset (hit_offset),
    .ack        (ack),
    .rd_strobe  (rd_strobe),
    .wr_strobe  (wr_strobe),
    .offset     (offset)
  );

  always_comb begin
    status         = '0;
    status.count   = count;
    status.freeze  = freeze;
    status.overrun = overrun;
    status.fresh   = fresh;
  end

  always_comb begin
    rd_mux = '0;
    case (hit_offset)
      WOFF_DATA:    rd_mux = data_reg;
      WOFF_STATUS:  rd_mux = pack_status(status);
      WOFF_CONTROL: rd_mux[CTRL_FREEZE_BIT] = freeze;
      default:      rd_mux = '0;
    endcase
  end

  // Read data is frozen at the hit edge and is non-zero only for the ack
  // cycle, keeping the wired-OR bus quiet otherwise.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      rd_q        <= '0;
      wr_clear_q  <= 1'b0;
      wr_freeze_q <= 1'b0;
      wr_be_q     <= 1'b0;
    end else begin
      rd_q <= (hit && OPB_RNW) ? rd_mux : '0;
      if (hit && !OPB_RNW) begin
        wr_clear_q  <= OPB_DBus[C_OPB_DWIDTH-1-CTRL_CLEAR_BIT];
        wr_freeze_q <= OPB_DBus[C_OPB_DWIDTH-1-CTRL_FREEZE_BIT];
        wr_be_q     <= OPB_BE[3];
      end
    end
  end

  assign capture    = user_data_valid && !freeze;
  assign data_read  = rd_strobe && (offset == WOFF_DATA);
  assign ctrl_write = wr_strobe && (offset == WOFF_CONTROL) && wr_be_q;
  assign ctrl_clear = ctrl_write && wr_clear_q;

  // A capture coinciding with a DATA read is not an overrun: software has just
  // consumed the previous word. A control clear beats any overrun set.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      data_reg <= '0;
      fresh    <= 1'b0;
      overrun  <= 1'b0;
      freeze   <= 1'b0;
      count    <= '0;
    end else begin
      if (capture) begin
        data_reg <= user_data_in;
      end

      if (capture) begin
        fresh <= 1'b1;
      end else if (data_read) begin
        fresh <= 1'b0;
      end

      if (ctrl_clear) begin
        overrun <= 1'b0;
      end else if (capture && fresh && !data_read) begin
        overrun <= 1'b1;
      end

      if (ctrl_clear) begin
        count <= capture ? 16'd1 : 16'd0;
      end else if (capture) begin
        count <= count + 16'd1;
      end

      if (ctrl_write) begin
        freeze <= wr_freeze_q;
      end
    end
  end

  assign Sl_DBus      = rd_q;
  assign Sl_xferAck   = ack;
  assign Sl_errAck    = 1'b0;
  assign Sl_retry     = 1'b0;
  assign Sl_toutSup   = 1'b0;
  assign user_overrun = overrun;

  assign unused_bits = ^{OPB_seqAddr, OPB_BE[0:2], OPB_DBus[0:C_OPB_DWIDTH-3]};

endmodule

// File: tb/tb_opb_register_simulink2ppc.sv
// Self-checking bench for opb_register_simulink2ppc: directed and randomized
// bus/capture traffic compared against a transaction-level model.
module tb_opb_register_simulink2ppc;

  localparam logic [31:0] BASE = 32'h01100200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [0:31] opb_abus = '0;
  logic [0:3]  opb_be = '0;
  logic [0:31] opb_dbus = '0;
  logic        opb_rnw = 1'b0;
  logic        opb_select = 1'b0;
  logic        opb_seqaddr = 1'b0;
  wire  [0:31] sl_dbus;
  wire         sl_errack;
  wire         sl_retry;
  wire         sl_toutsup;
  wire         sl_xferack;
  logic [31:0] user_data_in = '0;
  logic        user_data_valid = 1'b0;
  wire         user_overrun;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_data;
  bit          m_fresh;
  bit          m_overrun;
  bit          m_freeze;
  int          m_count;

  opb_register_simulink2ppc dut (
    .OPB_Clk         (clk),
    .OPB_Rst_n       (rst_n),
    .OPB_ABus        (opb_abus),
    .OPB_BE          (opb_be),
    .OPB_DBus        (opb_dbus),
    .OPB_RNW         (opb_rnw),
    .OPB_select      (opb_select),
    .OPB_seqAddr     (opb_seqaddr),
    .Sl_DBus         (sl_dbus),
    .Sl_errAck       (sl_errack),
    .Sl_retry        (sl_retry),
    .Sl_toutSup      (sl_toutsup),
    .Sl_xferAck      (sl_xferack),
    .user_data_in    (user_data_in),
    .user_data_valid (user_data_valid),
    .user_overrun    (user_overrun)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%08h expected=%08h", tag, observed, expected);
    end
  endtask

  function automatic void model_reset();
    m_data = '0; m_fresh = 0; m_overrun = 0; m_freeze = 0; m_count = 0;
  endfunction

  // One clock edge of register behaviour: a DATA read consumes the word,
  // then any capture lands, then a control write applies.
  function automatic void model_cycle(input bit rd_data, input bit clear,
                                      input bit fw, input bit fv,
                                      input bit valid, input logic [31:0] word);
    bit cap;
    bit old_fresh;
    cap = valid && !m_freeze;
    old_fresh = m_fresh;
    if (rd_data) m_fresh = 0;
    if (cap) begin
      if (old_fresh && !rd_data) m_overrun = 1;
      m_data  = word;
      m_fresh = 1;
      m_count = (m_count + 1) % 65536;
    end
    if (clear) begin
      m_overrun = 0;
      m_count   = cap ? 1 : 0;
    end
    if (fw) m_freeze = fv;
  endfunction

  function automatic logic [31:0] model_read(input int off);
    int v;
    case (off)
      0:       return m_data;
      4: begin
        v = m_count * 65536 + (m_freeze ? 4 : 0) + (m_overrun ? 2 : 0) + (m_fresh ? 1 : 0);
        return 32'(v);
      end
      8:       return m_freeze ? 32'd2 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic applyStimulus(input logic [31:0] addr, input logic rnw,
                               input logic [31:0] wdata, input logic [3:0] be,
                               input logic cap_en, input logic [31:0] cap_word,
                               output logic acked, output int lat,
                               output logic [31:0] rdata, output logic [31:0] idle_dbus);
    @(negedge clk);
    opb_abus = addr; opb_rnw = rnw; opb_dbus = wdata; opb_be = be; opb_select = 1'b1;
    acked = 1'b0; lat = 0; rdata = '0; idle_dbus = '0;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      if (sl_xferack) begin
        acked = 1'b1; lat = i; rdata = sl_dbus;
        break;
      end
      idle_dbus |= sl_dbus;
    end
    @(negedge clk);
    opb_select = 1'b0; opb_abus = '0; opb_dbus = '0; opb_be = '0; opb_rnw = 1'b0;
    if (acked && cap_en) begin
      user_data_in = cap_word; user_data_valid = 1'b1;
    end
    @(posedge clk); #1;
    idle_dbus |= sl_dbus;
    if (acked && sl_xferack) idle_dbus |= 32'hFFFF_FFFF;
    @(negedge clk);
    user_data_valid = 1'b0;
  endtask

  task automatic read_reg(input logic [31:0] addr, input logic cap_en,
                          input logic [31:0] cap_word, input string tag,
                          output logic [31:0] rdata);
    logic [31:0] exp;
    logic        acked;
    int          lat;
    logic [31:0] idle;
    int          off;
    off = int'(addr - BASE);
    exp = model_read(off);
    applyStimulus(addr, 1'b1, '0, 4'b0000, cap_en, cap_word, acked, lat, rdata, idle);
    checkOutput({tag, " ack"}, 32'(acked), 32'd1);
    checkOutput({tag, " latency"}, 32'(lat), 32'd1);
    checkOutput({tag, " data"}, rdata, exp);
    checkOutput({tag, " bus idle"}, idle, 32'd0);
    model_cycle(off == 0, 1'b0, 1'b0, 1'b0, cap_en, cap_word);
    checkOutput({tag, " user_overrun"}, 32'(user_overrun), 32'(m_overrun));
  endtask

  task automatic write_reg(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, input string tag);
    logic        acked;
    int          lat;
    logic [31:0] rdata;
    logic [31:0] idle;
    bit          ctrl;
    applyStimulus(addr, 1'b0, wdata, be, 1'b0, '0, acked, lat, rdata, idle);
    checkOutput({tag, " ack"}, 32'(acked), 32'd1);
    checkOutput({tag, " latency"}, 32'(lat), 32'd1);
    ctrl = (int'(addr - BASE) == 8) && be[0];
    model_cycle(1'b0, ctrl && wdata[0], ctrl, wdata[1], 1'b0, '0);
  endtask

  task automatic no_ack_access(input logic [31:0] addr, input string tag);
    logic        acked;
    int          lat;
    logic [31:0] rdata;
    logic [31:0] idle;
    applyStimulus(addr, 1'b1, '0, 4'b0000, 1'b0, '0, acked, lat, rdata, idle);
    checkOutput({tag, " no ack"}, 32'(acked), 32'd0);
    checkOutput({tag, " bus zero"}, idle, 32'd0);
  endtask

  task automatic pulse(input logic [31:0] word);
    @(negedge clk);
    user_data_in = word; user_data_valid = 1'b1;
    model_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, word);
    @(negedge clk);
    user_data_valid = 1'b0;
  endtask

  task automatic burst(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      user_data_in = $urandom; user_data_valid = 1'b1;
      model_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, user_data_in);
    end
    @(negedge clk);
    user_data_valid = 1'b0;
  endtask

  logic [31:0] rd;
  int          remaining;
  int          n;

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset ack", 32'(sl_xferack), 32'd0);
    checkOutput("reset dbus", sl_dbus, 32'd0);
    checkOutput("reset user_overrun", 32'(user_overrun), 32'd0);
    checkOutput("const outputs", {29'd0, sl_errack, sl_retry, sl_toutsup}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] basic reads after reset");
    read_reg(BASE + 32'h0, 1'b0, '0, "rst DATA", rd);
    read_reg(BASE + 32'h4, 1'b0, '0, "rst STATUS", rd);

    pulse(32'hDEADBEEF);
    read_reg(BASE + 32'h0, 1'b0, '0, "DATA beef", rd);
    checkOutput("DATA beef const", rd, 32'hDEADBEEF);
    read_reg(BASE + 32'h4, 1'b0, '0, "STATUS after read", rd);
    checkOutput("STATUS after read const", rd, 32'h0001_0000);

    $display("[TB] overrun and clear");
    pulse(32'h1);
    pulse(32'h2);
    read_reg(BASE + 32'h4, 1'b0, '0, "STATUS overrun", rd);
    checkOutput("STATUS overrun const", rd, 32'h0003_0003);
    write_reg(BASE + 32'h8, 32'h1, 4'b0001, "CTRL clear");
    read_reg(BASE + 32'h4, 1'b0, '0, "STATUS cleared", rd);
    checkOutput("STATUS cleared const", rd, 32'h0000_0001);

    $display("[TB] freeze");
    write_reg(BASE + 32'h8, 32'h2, 4'b0001, "CTRL freeze");
    read_reg(BASE + 32'h8, 1'b0, '0, "CTRL readback", rd);
    pulse(32'h55);
    read_reg(BASE + 32'h0, 1'b0, '0, "DATA frozen", rd);
    checkOutput("DATA frozen const", rd, 32'h2);
    read_reg(BASE + 32'h4, 1'b0, '0, "STATUS frozen", rd);
    write_reg(BASE + 32'h8, 32'h2, 4'b1110, "CTRL masked BE");
    write_reg(BASE + 32'h8, 32'h0, 4'b0001, "CTRL unfreeze");
    pulse(32'h55);
    read_reg(BASE + 32'h0, 1'b0, '0, "DATA unfrozen", rd);
    checkOutput("DATA unfrozen const", rd, 32'h55);

    $display("[TB] capture during DATA ack");
    pulse(32'h11111111);
    read_reg(BASE + 32'h0, 1'b1, 32'hAAAA5555, "DATA coincident", rd);
    checkOutput("DATA coincident const", rd, 32'h11111111);
    read_reg(BASE + 32'h4, 1'b0, '0, "STATUS coincident", rd);
    checkOutput("STATUS coincident flags", rd & 32'h3, 32'h1);
    read_reg(BASE + 32'h0, 1'b0, '0, "DATA new word", rd);

    $display("[TB] randomized traffic");
    for (int k = 0; k < 30; k++) begin
      case ($urandom_range(0, 4))
        0: pulse($urandom);
        1: read_reg(BASE + 32'h0, 1'($urandom_range(0, 1)), $urandom, "rnd DATA", rd);
        2: read_reg(BASE + 32'h4, 1'b0, '0, "rnd STATUS", rd);
        3: write_reg(BASE + 32'h8, 32'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), "rnd CTRL");
        default: read_reg(BASE + 32'(4 * $urandom_range(3, 63)), 1'b0, '0, "rnd high", rd);
      endcase
    end
    write_reg(BASE + 32'h8, 32'h1, 4'b0001, "CTRL clear+unfreeze");
    read_reg(BASE + 32'h8, 1'b0, '0, "CTRL after clear", rd);
    checkOutput("CTRL after clear const", rd, 32'h0);

    $display("[TB] count wrap");
    remaining = 65536;
    while (remaining > 0) begin
      n = $urandom_range(3000, 15000);
      if (n > remaining) n = remaining;
      burst(n);
      remaining -= n;
      read_reg(BASE + 32'h4, 1'b0, '0, "wrap STATUS", rd);
    end
    checkOutput("wrap count", rd >> 16, 32'd0);

    $display("[TB] window edges");
    read_reg(BASE + 32'h40, 1'b0, '0, "offset 0x40", rd);
    checkOutput("offset 0x40 const", rd, 32'h0);
    read_reg(BASE + 32'hFC, 1'b0, '0, "offset 0xFC", rd);
    write_reg(BASE + 32'h0, 32'hFFFFFFFF, 4'b1111, "write DATA ignored");
    write_reg(BASE + 32'hC, 32'hFFFFFFFF, 4'b1111, "write 0x0C ignored");
    read_reg(BASE + 32'h4, 1'b0, '0, "STATUS after ignored", rd);
    no_ack_access(BASE + 32'h100, "above window");
    no_ack_access(BASE - 32'h4, "below window");

    $display("[TB] reset mid-transaction");
    pulse(32'h77);
    pulse(32'h78);
    checkOutput("pre-reset user_overrun", 32'(user_overrun), 32'd1);
    @(negedge clk);
    opb_abus = BASE + 32'h4; opb_rnw = 1'b1; opb_select = 1'b1;
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    checkOutput("abort ack", 32'(sl_xferack), 32'd0);
    checkOutput("abort dbus", sl_dbus, 32'd0);
    checkOutput("abort user_overrun", 32'(user_overrun), 32'd0);
    @(posedge clk); #1;
    checkOutput("abort ack later", 32'(sl_xferack), 32'd0);
    @(negedge clk);
    opb_select = 1'b0; opb_abus = '0;
    rst_n = 1'b1;
    model_reset();
    read_reg(BASE + 32'h4, 1'b0, '0, "post-reset STATUS", rd);
    read_reg(BASE + 32'h0, 1'b0, '0, "post-reset DATA", rd);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
